multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control unit for the multi-cycle RISC-V core. It sequences the shared ALU, register file, instruction register and unified memory port through fetch, decode, execute, memory and writeback states. It drives the 3-bit ALU control code and the mux selects. It includes a memory-ready handshake so fetch and memory states can stall on slow memory.

Parameters:
none (opcode and ALU codes are fixed constants in the package)

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces FETCH immediately
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pcwrite  output  1  PC register enable
adrsrc  output  1  memory address select: 0=PC, 1=ALUOut/result
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register and oldPC enable
resultsrc  output  2  00=ALUOut, 01=mem data, 10=ALU result direct
alusrca  output  2  00=PC, 01=oldPC, 10=rs1
alusrcb  output  2  00=rs2, 01=immext, 10=constant 4
immsrc  output  2  00=I, 01=S, 10=B, 11=J
alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
regwrite  output  1  register file write enable
state_dbg  output  4  current state encoding, for the bench

Behaviour:
- Reset: state=FETCH asynchronously. All outputs are Moore decodes of state, except pcwrite, irwrite and memwrite, which are gated by mem_ready or zero. In reset with mem_ready=0, all enables are 0, alusrca=00, alusrcb=10, resultsrc=10, alucontrol=000.
- States, with default outputs 0/00:
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10. When mem_ready=1: irwrite=1, pcwrite=1, next=DECODE. Else hold with no enables.
  - DECODE: alusrca=01, alusrcb=01, add (branch target into ALUOut). Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other -> FETCH (NOP, no side effects).
  - MEMADR: alusrca=10, alusrcb=01, add. Next is MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready=1, then MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, then FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00. memwrite=1 every cycle until and including the mem_ready=1 cycle, then FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, ALU decode, then ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, ALU decode, then ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, then FETCH.
  - BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00, pcwrite=zero, then FETCH.
  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1, then ALUWB (writes oldPC+4 to rd).
- immsrc is decoded from op combinationally in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- ALU decode, applied in EXECUTER/EXECUTEI only, by funct3:
  - 000: sub if op[5]&funct7b5, else add.
  - 010: slt 101.
  - 110: or 011.
  - 111: and 010.
  - other: add 000.
- Latency in cycles with mem_ready=1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each stall cycle adds 1.
- Reset mid-instruction: the instruction is abandoned, no further regwrite/memwrite, restart in FETCH.
- Illegal alucontrol codes (100, 110, 111) are never generated.

Decomposition:
- Package ctrl_pkg: state enum (4-bit), opcode constants, alucontrol codes, mux-select constants.
- Sub-module alu_decoder (combinational): inputs aluop[1:0] (00 add, 01 sub, 10 funct), funct3, funct7b5, op5; output alucontrol.
- FSM and output decode stay in the top module.

Test Plan:
- lw, op=0000011, mem_ready=1: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. regwrite=1 only in MEMWB with resultsrc=01. pcwrite/irwrite=1 only in FETCH.
- sub R-type, op=0110011, funct3=000, funct7b5=1: alucontrol=001 in EXECUTER. With funct7b5=0: 000. funct3=111 gives 010, 110 gives 011, 010 gives 101.
- beq: zero=1 gives pcwrite=1 in BEQ with alucontrol=001. zero=0 gives pcwrite=0. Next state FETCH in both cases.
- sw with mem_ready low 3 cycles: memwrite=1 for 4 consecutive cycles, adrsrc=1, then FETCH. FETCH with mem_ready=0 holds with irwrite=0.
- Unknown op=1111111: FETCH, DECODE, FETCH with no regwrite/memwrite. jal: pcwrite=1 in JAL, then ALUWB regwrite=1.
- Assert reset during EXECUTEI: state_dbg=FETCH in the same cycle, no regwrite. After release, normal fetch resumes.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle RISC-V control unit: FSM state
// encoding, opcodes, ALU control codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_for_op(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the controller and the multi-cycle datapath:
// instruction fields and flags in, enables and mux selects out.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;
  logic       regwrite;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
           alusrcb, immsrc, alucontrol, regwrite, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
           alusrcb, immsrc, alucontrol, regwrite, state_dbg
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: fixed add/sub for address and branch work, or a
// funct3/funct7 decode for R-type and I-type arithmetic.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // Only legal codes are produced; sub needs op[5] so addi never subtracts.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle core. Outputs are Moore decodes of
// the state, except the PC/IR/memory-write enables which also look at
// mem_ready or the ALU zero flag.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] alucontrol;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .alucontrol (alucontrol)
  );

  // State register; reset abandons any instruction and restarts fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state and output decode; memory states stall until mem_ready.
  always_comb begin
    next_state = state;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        if (bus.mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTER;
          OP_ITYPE:     next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = RES_MEM;
        regwrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca    = SRCA_RS1;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = SRCA_RS1;
        aluop      = ALUOP_SUB;
        pcwrite    = bus.zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        pcwrite    = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.pcwrite    = pcwrite;
  assign bus.adrsrc     = adrsrc;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.resultsrc  = resultsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.immsrc     = imm_for_op(bus.op);
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for the multi-cycle controller: each instruction pushes
// its expected per-cycle outputs (with the mem_ready/zero to drive in that
// cycle), then the queue is drained one cycle at a time against the DUT.
module tb_multicycle_controller;

  typedef struct {
    logic [3:0] st;
    logic       pcw, irw, mw, rw, adr;
    logic [1:0] res, sa, sb;
    logic [2:0] ctl;
    logic       mr, z;
  } cyc_t;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  cyc_t sb_q[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [3:0] st, input logic pcw,
                              input logic irw, input logic mw, input logic rw,
                              input logic adr, input logic [1:0] res,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] ctl, input logic mr,
                              input logic z);
    cyc_t c;
    c.st = st; c.pcw = pcw; c.irw = irw; c.mw = mw; c.rw = rw; c.adr = adr;
    c.res = res; c.sa = sa; c.sb = sb; c.ctl = ctl; c.mr = mr; c.z = z;
    return c;
  endfunction

  // Sets the instruction fields and checks the op-only immediate decode.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7b5, input logic [1:0] exp_imm);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7b5;
    #1;
    checkOutput($sformatf("immsrc op=%b", op), 32'(bus.immsrc), 32'(exp_imm));
  endtask

  task automatic pushFetch(input logic mr);
    sb_q.push_back(mk(4'd0, mr, mr, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, mr, 0));
  endtask

  task automatic pushDecode();
    sb_q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1, 0));
  endtask

  // Drains the scoreboard: drive this cycle's inputs, then compare.
  task automatic runQueue(input string name);
    cyc_t c;
    int   cyc;
    cyc = 0;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk);
      bus.mem_ready = c.mr;
      bus.zero      = c.z;
      #1;
      checkOutput($sformatf("%s c%0d state", name, cyc), 32'(bus.state_dbg), 32'(c.st));
      checkOutput($sformatf("%s c%0d pcwrite", name, cyc), 32'(bus.pcwrite), 32'(c.pcw));
      checkOutput($sformatf("%s c%0d irwrite", name, cyc), 32'(bus.irwrite), 32'(c.irw));
      checkOutput($sformatf("%s c%0d memwrite", name, cyc), 32'(bus.memwrite), 32'(c.mw));
      checkOutput($sformatf("%s c%0d regwrite", name, cyc), 32'(bus.regwrite), 32'(c.rw));
      checkOutput($sformatf("%s c%0d adrsrc", name, cyc), 32'(bus.adrsrc), 32'(c.adr));
      checkOutput($sformatf("%s c%0d resultsrc", name, cyc), 32'(bus.resultsrc), 32'(c.res));
      checkOutput($sformatf("%s c%0d alusrca", name, cyc), 32'(bus.alusrca), 32'(c.sa));
      checkOutput($sformatf("%s c%0d alusrcb", name, cyc), 32'(bus.alusrcb), 32'(c.sb));
      checkOutput($sformatf("%s c%0d alucontrol", name, cyc), 32'(bus.alucontrol), 32'(c.ctl));
      cyc++;
    end
  endtask

  // R-type funct3/funct7b5 patterns and the ALU code each must produce.
  logic [2:0] r_f3  [6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b100};
  logic       r_f7  [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
  logic [2:0] r_exp [6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b000};

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b1;
    bus.op        = 7'd0;
    bus.funct3    = 3'd0;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("reset state", 32'(bus.state_dbg), 32'd0);
    checkOutput("reset pcwrite", 32'(bus.pcwrite), 32'd0);
    checkOutput("reset irwrite", 32'(bus.irwrite), 32'd0);
    checkOutput("reset memwrite", 32'(bus.memwrite), 32'd0);
    checkOutput("reset regwrite", 32'(bus.regwrite), 32'd0);
    checkOutput("reset alusrca", 32'(bus.alusrca), 32'd0);
    checkOutput("reset alusrcb", 32'(bus.alusrcb), 32'd2);
    checkOutput("reset resultsrc", 32'(bus.resultsrc), 32'd2);
    checkOutput("reset alucontrol", 32'(bus.alucontrol), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // lw with one memory stall in MEMREAD
    applyStimulus(7'b0000011, 3'b010, 1'b0, 2'b00);
    pushFetch(1);
    pushDecode();
    sb_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 1, 0));
    sb_q.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
    sb_q.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
    sb_q.push_back(mk(4'd4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
    runQueue("lw");

    // R-type ALU decode table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(7'b0110011, r_f3[i], r_f7[i], 2'b00);
      pushFetch(1);
      pushDecode();
      sb_q.push_back(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, r_exp[i], 1, 0));
      sb_q.push_back(mk(4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      runQueue($sformatf("rtype%0d", i));
    end

    // addi with instr[30] set must still add (op[5]=0)
    applyStimulus(7'b0010011, 3'b000, 1'b1, 2'b00);
    pushFetch(1);
    pushDecode();
    sb_q.push_back(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 1, 0));
    sb_q.push_back(mk(4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
    runQueue("addi");

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(7'b1100011, 3'b000, 1'b0, 2'b10);
      pushFetch(1);
      pushDecode();
      sb_q.push_back(mk(4'd9, 1'(z), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 1'(z)));
      runQueue($sformatf("beq z=%0d", z));
    end

    // sw: fetch stalls twice, then memwrite held for four cycles
    applyStimulus(7'b0100011, 3'b010, 1'b0, 2'b01);
    pushFetch(0);
    pushFetch(0);
    pushFetch(1);
    pushDecode();
    sb_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 1, 0));
    for (int i = 0; i < 4; i++)
      sb_q.push_back(mk(4'd5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, (i == 3), 0));
    runQueue("sw");

    // unknown opcode returns straight to FETCH without side effects
    applyStimulus(7'b1111111, 3'b000, 1'b0, 2'b00);
    pushFetch(1);
    pushDecode();
    pushFetch(0);
    runQueue("nop");

    // jal: PC update in JAL, link write in ALUWB
    applyStimulus(7'b1101111, 3'b000, 1'b0, 2'b11);
    pushFetch(1);
    pushDecode();
    sb_q.push_back(mk(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 1, 0));
    sb_q.push_back(mk(4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
    runQueue("jal");

    // reset asserted in EXECUTEI abandons the instruction at once
    applyStimulus(7'b0010011, 3'b111, 1'b0, 2'b00);
    pushFetch(1);
    pushDecode();
    runQueue("pre-reset");
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("mid EXECUTEI state", 32'(bus.state_dbg), 32'd7);
    checkOutput("mid EXECUTEI alucontrol", 32'(bus.alucontrol), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset state", 32'(bus.state_dbg), 32'd0);
    checkOutput("async reset regwrite", 32'(bus.regwrite), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held reset state", 32'(bus.state_dbg), 32'd0);
    checkOutput("held reset regwrite", 32'(bus.regwrite), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    // normal andi after reset release
    applyStimulus(7'b0010011, 3'b111, 1'b0, 2'b00);
    pushFetch(1);
    pushDecode();
    sb_q.push_back(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 1, 0));
    sb_q.push_back(mk(4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
    pushFetch(0);
    runQueue("post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
